dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 14 +
 rtl/dmem_ctrl_load_extend.sv | 15 +
 rtl/dmem_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared load/store encodings, default widths and byte-count helpers
package dmem_ctrl_pkg;
   localparam int          DEF_ROB_SIZE_WIDTH = 4;
   localparam logic [31:0] DEF_IO_BASE        = 32'h0003_0000;
   typedef enum logic [2:0] {LD_LB = 3'd0, LD_LH = 3'd1, LD_LW = 3'd2, LD_LBU = 3'd3, LD_LHU = 3'd4} ld_type_e;
   typedef enum logic [1:0] {ST_B = 2'd0, ST_H = 2'd1, ST_W = 2'd2} st_size_e;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_e;
   function automatic logic [2:0] ld_bytes(input logic [2:0] t);
      return (t == LD_LB || t == LD_LBU) ? 3'd1 : (t == LD_LH || t == LD_LHU) ? 3'd2 : 3'd4;
   endfunction
   function automatic logic [1:0] st_bytes_m1(input logic [1:0] s);
      return (s == ST_B) ? 2'd0 : (s == ST_H) ? 2'd1 : 2'd3;
   endfunction
endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// load_extend: sign/zero extension of an assembled little-endian load word
module load_extend
   import dmem_ctrl_pkg::*;
(
   input  logic [2:0]  load_type,
   input  logic [31:0] raw,
   output logic [31:0] value
);
   // pick the extension matching the load type; LW passes through
   always_comb
      value = (load_type == LD_LB)  ? {{24{raw[7]}}, raw[7:0]} :
              (load_type == LD_LH)  ? {{16{raw[15]}}, raw[15:0]} :
              (load_type == LD_LBU) ? {24'b0, raw[7:0]} :
              (load_type == LD_LHU) ? {16'b0, raw[15:0]} : raw;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-serial data memory controller for loads and committed stores
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int          ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH,
   parameter logic [31:0] IO_BASE        = DEF_IO_BASE
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      need_flush_in,
   input  logic                      lb_ready_in,
   input  logic [2:0]                lb_load_type_in,
   input  logic [31:0]               lb_addr_in,
   input  logic [ROB_SIZE_WIDTH-1:0] lb_dependency_in,
   input  logic                      st_valid_in,
   input  logic [1:0]                st_size_in,
   input  logic [31:0]               st_addr_in,
   input  logic [31:0]               st_value_in,
   input  logic [7:0]                mem_din,
   input  logic                      io_buffer_full,
   output logic [7:0]                mem_dout,
   output logic [31:0]               mem_a,
   output logic                      mem_wr,
   output logic                      mem_busy,
   output logic                      mem_valid,
   output logic [ROB_SIZE_WIDTH-1:0] mem_dependency,
   output logic [31:0]               mem_value,
   output logic                      st_done
);
   state_e                    state_q, state_d;
   logic [2:0]                cnt_q, cnt_d, n_q, n_d, typ_q, typ_d;
   logic [31:0]               base_q, base_d, val_q, val_d, mem_a_q, mem_a_d, mem_value_q, mem_value_d;
   logic [ROB_SIZE_WIDTH-1:0] tag_q, tag_d, mem_dep_q, mem_dep_d;
   logic [7:0]                mem_dout_q, mem_dout_d;
   logic                      mem_wr_q, mem_wr_d, mem_valid_q, mem_valid_d, st_done_q, st_done_d;
   logic [31:0]               wr_addr, raw, ext;
   logic                      io_hold;
   assign wr_addr = (state_q == S_IDLE) ? st_addr_in : base_q + {29'b0, cnt_q};
   assign io_hold = io_buffer_full && (wr_addr >= IO_BASE);
   // merge the byte arriving this cycle into the partially assembled load word
   always_comb begin
      raw = val_q;
      raw[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
   end
   load_extend u_ext (.load_type(typ_q), .raw(raw), .value(ext));
   // next-state logic; rdy_in low holds everything and drops the pulse outputs
   always_comb begin
      state_d = state_q; cnt_d = cnt_q; n_d = n_q; typ_d = typ_q; base_d = base_q; val_d = val_q; tag_d = tag_q;
      mem_a_d = mem_a_q; mem_dout_d = mem_dout_q; mem_dep_d = mem_dep_q; mem_value_d = mem_value_q;
      mem_wr_d = 1'b0; mem_valid_d = 1'b0; st_done_d = 1'b0;
      if (rdy_in) begin
         case (state_q)
            S_IDLE:
               if (st_valid_in) begin
                  state_d = S_STORE; n_d = {1'b0, st_size_in == ST_B ? 2'd1 : 2'd0} + {st_bytes_m1(st_size_in) == 2'd3, st_size_in == ST_H, 1'b0};
                  base_d = st_addr_in; val_d = st_value_in; mem_a_d = st_addr_in; mem_dout_d = st_value_in[7:0];
                  mem_wr_d = !io_hold; cnt_d = io_hold ? 3'd0 : 3'd1;
               end else if (lb_ready_in && !need_flush_in) begin
                  state_d = S_LOAD; n_d = ld_bytes(lb_load_type_in); typ_d = lb_load_type_in;
                  base_d = lb_addr_in; tag_d = lb_dependency_in; mem_a_d = lb_addr_in; cnt_d = 3'd0; val_d = 32'b0;
               end
            S_STORE:
               if (cnt_q == n_q) begin
                  state_d = S_IDLE; st_done_d = 1'b1;
               end else begin
                  mem_a_d = wr_addr; mem_dout_d = val_q[{cnt_q[1:0], 3'b000} +: 8];
                  mem_wr_d = !io_hold; cnt_d = io_hold ? cnt_q : cnt_q + 3'd1;
               end
            S_LOAD:
               if (need_flush_in) state_d = S_IDLE;
               else begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q + 3'd1 < n_q) mem_a_d = wr_addr + 32'd1;
                  if (cnt_q != 3'd0) val_d = raw;
                  if (cnt_q == n_q) begin
                     state_d = S_IDLE; mem_valid_d = 1'b1; mem_dep_d = tag_q; mem_value_d = ext;
                  end
               end
            default: state_d = S_IDLE;
         endcase
      end
   end
   // state and registered outputs; reset discards any operation in flight
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE; cnt_q <= '0; n_q <= '0; typ_q <= '0; base_q <= '0; val_q <= '0; tag_q <= '0;
         mem_a_q <= '0; mem_dout_q <= '0; mem_wr_q <= 1'b0; mem_valid_q <= 1'b0; mem_dep_q <= '0;
         mem_value_q <= '0; st_done_q <= 1'b0;
      end else begin
         state_q <= state_d; cnt_q <= cnt_d; n_q <= n_d; typ_q <= typ_d; base_q <= base_d; val_q <= val_d; tag_q <= tag_d;
         mem_a_q <= mem_a_d; mem_dout_q <= mem_dout_d; mem_wr_q <= mem_wr_d; mem_valid_q <= mem_valid_d;
         mem_dep_q <= mem_dep_d; mem_value_q <= mem_value_d; st_done_q <= st_done_d;
      end
   end
   assign mem_a = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr = mem_wr_q;
   assign mem_busy = (state_q != S_IDLE);
   assign mem_valid = mem_valid_q;
   assign mem_dependency = mem_dep_q;
   assign mem_value = mem_value_q;
   assign st_done = st_done_q;
endmodule
